byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Sits directly downstream of the team's 8-bit byte FIFO.
- Drains bytes with a read strobe, honouring the FIFO's empty flag and its one-cycle registered read data.
- Packs bytes little-endian into BYTES_PER_WORD-wide words and presents them on a valid/ready output port.
- A flush request emits any partial word, tagged with its byte count.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; integer ≥ 2.
- CNT_W, $clog2(BYTES_PER_WORD)+1, width of byte-count fields (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_fifo_empty  input  1  upstream FIFO empty flag.
- in_fifo_data  input  8  upstream read data; valid in the cycle after out_fifo_read was high.
- out_fifo_read  output  1  upstream read strobe; one byte per high cycle.
- in_flush  input  1  single-cycle flush request.
- out_word_valid  output  1  output word available.
- in_word_ready  input  1  sink accepts the word when valid && ready.
- out_word_data  output  8*BYTES_PER_WORD  packed word; byte k on bits [8k+7:8k].
- out_word_nbytes  output  CNT_W  valid bytes in out_word_data (1..BYTES_PER_WORD).
- out_flush_done  output  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset values: out_fifo_read=0, out_word_valid=0, out_word_data=0, out_word_nbytes=0, out_flush_done=0. Internal state: byte count=0, pending=0, state=FILL.
- rst wins over all inputs. Reset mid-operation discards the pending byte and the partial word; the upstream FIFO shares rst.
- Internal state: assembly register, cnt (0..BYTES_PER_WORD), pending flag (a read was issued last cycle), output register.
- out_fifo_read is combinational and is never high while in_fifo_empty=1.
- Read condition: state==FILL && !in_fifo_empty && (cnt_eff + pending) < BYTES_PER_WORD.
  - cnt_eff = 0 if a full-word transfer to the output register occurs this cycle; otherwise cnt_eff = cnt.
- Byte landing: when pending=1, in_fifo_data is written into lane cnt and cnt increments. pending <= out_fifo_read.
- Transfer to output register:
  - Condition: cnt==BYTES_PER_WORD && (!out_word_valid || in_word_ready).
  - Effect: out_word_data <= assembly, out_word_nbytes <= BYTES_PER_WORD, out_word_valid <= 1, cnt <= 0.
  - A byte landing in the same cycle goes to lane 0 of the new assembly (cnt <= 1).
- Output handshake:
  - out_word_valid drops after valid && ready unless a new transfer loads in the same cycle.
  - out_word_data and out_word_nbytes are stable while valid && !ready.
- Steady-state throughput with ready=1 and the FIFO never empty: one word per BYTES_PER_WORD+1 cycles.
- First-byte latency: read at cycle t, byte lands at t+1. A full word is valid BYTES_PER_WORD+2 cycles after the first read.
- State machine:
  - FILL: normal operation. in_flush=1 -> FLUSH_WAIT; no read is issued in that cycle.
  - FLUSH_WAIT: no reads. Waits for pending==0 (the last byte has landed).
    - If cnt==0: pulse out_flush_done and go to FILL.
    - Else go to FLUSH_EMIT.
  - FLUSH_EMIT: when output register free (!out_word_valid || in_word_ready), load it.
    - out_word_nbytes <= cnt; unused lanes are zero.
    - cnt <= 0; pulse out_flush_done; go to FILL.
  - A full word (cnt==BYTES_PER_WORD) during FLUSH_WAIT is emitted through the normal transfer path, then the flush completes with cnt==0.
- in_flush outside FILL is ignored.
- Width rules:
  - cnt never exceeds BYTES_PER_WORD.
  - out_word_nbytes is never 0 while out_word_valid=1.

Test Plan:
- Reset, push bytes 0x11,0x22,0x33,0x44 into the FIFO, ready=1 -> one word 0x44332211, nbytes=4; out_fifo_read high exactly 4 cycles, never while empty.
- Stream 8 bytes 0x01..0x08, ready held 0 until both words are packed -> first word 0x04030201 holds stable and reading stalls at cnt=4; after ready=1, words 0x04030201 then 0x08070605 in order, no loss.
- Push 0xAA,0xBB then pulse in_flush -> word 0x0000BBAA, nbytes=2, out_flush_done pulses one cycle after the word loads; then push 4 bytes -> normal full word.
- Pulse in_flush with cnt=0 and no pending read -> no word emitted; out_flush_done pulses within 2 cycles.
- Assert rst with 3 bytes assembled and one read pending -> next cycle all outputs at reset values; subsequent bytes 0x55..0x58 yield 0x58575655.
- Random empty/ready toggling over 1000 bytes with a scoreboard -> byte order preserved; assertions hold: no read while empty, stable data while valid && !ready.

Source files
------------

// File: rtl/byte_word_packer.sv
// Drains an 8-bit byte FIFO and packs the bytes little-endian into words on a valid/ready port.
// A flush request emits any partial word with its byte count.
module byte_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = $clog2(BYTES_PER_WORD) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_fifo_empty,
    input  logic [7:0]                  in_fifo_data,
    output logic                        out_fifo_read,
    input  logic                        in_flush,
    output logic                        out_word_valid,
    input  logic                        in_word_ready,
    output logic [8*BYTES_PER_WORD-1:0] out_word_data,
    output logic [CNT_W-1:0]            out_word_nbytes,
    output logic                        out_flush_done
);

    localparam int               W    = 8 * BYTES_PER_WORD;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        FILL,
        FLUSH_WAIT,
        FLUSH_EMIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [W-1:0]     asm_q, asm_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] nbytes_q, nbytes_d;
    logic             flush_done_q, flush_done_d;

    logic             out_free;
    logic             xfer;
    logic             rd;
    logic [CNT_W-1:0] cnt_eff;
    logic [W-1:0]     partial;

    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
    always_comb begin
        out_free     = !valid_q || in_word_ready;
        xfer         = (cnt_q == FULL) && out_free;
        cnt_eff      = xfer ? '0 : cnt_q;
        // The pending byte reserves its lane, so reads stop one byte short of a full assembly.
        rd           = !rst && (state_q == FILL) && !in_flush && !in_fifo_empty
                       && ((cnt_eff + CNT_W'(pending_q)) < FULL);

        state_d      = state_q;
        cnt_d        = cnt_eff;
        pending_d    = rd;
        asm_d        = asm_q;
        valid_d      = valid_q && !in_word_ready;
        data_d       = data_q;
        nbytes_d     = nbytes_q;
        flush_done_d = 1'b0;

        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            partial[8*k +: 8] = (CNT_W'(k) < cnt_q) ? asm_q[8*k +: 8] : 8'h00;
        end

        if (xfer) begin
            data_d   = asm_q;
            nbytes_d = FULL;
            valid_d  = 1'b1;
        end

        if (pending_q) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (cnt_eff == CNT_W'(k)) begin
                    asm_d[8*k +: 8] = in_fifo_data;
                end
            end
            cnt_d = cnt_eff + CNT_W'(1);
        end

        case (state_q)
            FILL: begin
                if (in_flush) begin
                    state_d = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                // A full assembly leaves through the normal transfer; the flush then completes with cnt==0.
                if (!pending_q) begin
                    if (cnt_q == '0) begin
                        flush_done_d = 1'b1;
                        state_d      = FILL;
                    end else if (cnt_q != FULL) begin
                        state_d = FLUSH_EMIT;
                    end
                end
            end
            FLUSH_EMIT: begin
                if (out_free) begin
                    data_d       = partial;
                    nbytes_d     = cnt_q;
                    valid_d      = 1'b1;
                    cnt_d        = '0;
                    flush_done_d = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            // NOTE: the assembly register is reset as well; it is a handful of flops, not a RAM.
            asm_q        <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            nbytes_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            asm_q        <= asm_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            nbytes_q     <= nbytes_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign out_fifo_read   = rd;
    assign out_word_valid  = valid_q;
    assign out_word_data   = data_q;
    assign out_word_nbytes = nbytes_q;
    assign out_flush_done  = flush_done_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer: an upstream FIFO model, a byte-stream scoreboard
// that forms expected words from bytes read, and directed scenarios with literal expectations.
module tb_byte_word_packer;

    localparam int BPW   = 4;
    localparam int CNT_W = $clog2(BPW) + 1;
    localparam int W     = 8 * BPW;

    logic             clk;
    logic             rst;
    logic             in_fifo_empty;
    logic [7:0]       in_fifo_data;
    logic             out_fifo_read;
    logic             in_flush;
    logic             out_word_valid;
    logic             in_word_ready;
    logic [W-1:0]     out_word_data;
    logic [CNT_W-1:0] out_word_nbytes;
    logic             out_flush_done;

    byte_word_packer #(.BYTES_PER_WORD(BPW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_fifo_empty   (in_fifo_empty),
        .in_fifo_data    (in_fifo_data),
        .out_fifo_read   (out_fifo_read),
        .in_flush        (in_flush),
        .out_word_valid  (out_word_valid),
        .in_word_ready   (in_word_ready),
        .out_word_data   (out_word_data),
        .out_word_nbytes (out_word_nbytes),
        .out_flush_done  (out_flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           nbytes;
    } word_t;

    logic [7:0] src_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] acc_q[$];
    word_t      exp_q[$];
    logic       src_en;
    logic       rd_lat;

    function automatic word_t take_acc();
        word_t w;
        w.data   = '0;
        w.nbytes = acc_q.size();
        for (int i = 0; i < acc_q.size(); i++) w.data[8*i +: 8] = acc_q[i];
        acc_q.delete();
        return w;
    endfunction

    // Upstream FIFO with registered read data, plus the reference byte-stream model.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            acc_q.delete();
            exp_q.delete();
            in_fifo_empty <= 1'b1;
            in_fifo_data  <= 8'h00;
        end else begin
            if (rd_lat && fifo_q.size() > 0) begin
                logic [7:0] b;
                b = fifo_q.pop_front();
                in_fifo_data <= b;
                acc_q.push_back(b);
                if (acc_q.size() == BPW) exp_q.push_back(take_acc());
            end
            if (in_flush && acc_q.size() > 0) exp_q.push_back(take_acc());
            if (src_en && src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
            in_fifo_empty <= (fifo_q.size() == 0);
        end
    end

    int           cyc = 0;
    int           reads_seen = 0;
    int           words_seen = 0;
    int           bytes_out = 0;
    int           flush_seen = 0;
    int           flush_cyc = 0;
    logic [W-1:0] last_word = '0;
    int           last_nbytes = 0;
    logic         prev_hold = 1'b0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [CNT_W-1:0] prev_nbytes = '0;
    int           read_cyc_q[$];
    int           rise_cyc_q[$];

    // Compare process: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rd_lat     <= 1'b0;
            prev_hold  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            rd_lat <= out_fifo_read;
            if (out_fifo_read) begin
                check("read_while_empty", {63'd0, in_fifo_empty}, 64'd0);
                reads_seen <= reads_seen + 1;
                read_cyc_q.push_back(cyc);
            end
            if (out_word_valid && !prev_valid) rise_cyc_q.push_back(cyc);
            if (out_word_valid)
                check("nbytes_range", {63'd0, (out_word_nbytes >= 1 && out_word_nbytes <= BPW)}, 64'd1);
            if (prev_hold) begin
                check("hold_valid", {63'd0, out_word_valid}, 64'd1);
                check("hold_data", 64'(out_word_data), 64'(prev_data));
                check("hold_nbytes", 64'(out_word_nbytes), 64'(prev_nbytes));
            end
            if (out_word_valid && in_word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(out_word_data), 64'hDEAD);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word_data", 64'(out_word_data), 64'(w.data));
                    check("word_nbytes", 64'(out_word_nbytes), 64'(w.nbytes));
                end
                last_word   <= out_word_data;
                last_nbytes <= int'(out_word_nbytes);
                words_seen  <= words_seen + 1;
                bytes_out   <= bytes_out + int'(out_word_nbytes);
            end
            if (out_flush_done) begin
                flush_seen <= flush_seen + 1;
                flush_cyc  <= cyc;
            end
            prev_hold   <= out_word_valid && !in_word_ready;
            prev_valid  <= out_word_valid;
            prev_data   <= out_word_data;
            prev_nbytes <= out_word_nbytes;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] bs[4];
        bs = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) src_q.push_back(bs[i]);
    endtask

    int r0, w0, f0, b0;
    logic seen;

    initial begin
        rst = 1'b1; src_en = 1'b0; in_flush = 1'b0; in_word_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", {63'd0, out_word_valid}, 64'd0);
        check("rst_data", 64'(out_word_data), 64'd0);
        check("rst_nbytes", 64'(out_word_nbytes), 64'd0);
        check("rst_flush_done", {63'd0, out_flush_done}, 64'd0);
        check("rst_read", {63'd0, out_fifo_read}, 64'd0);
        rst = 1'b0;
        tick();

        // One full word, ready high throughout.
        in_word_ready = 1'b1; src_en = 1'b1;
        read_cyc_q.delete(); rise_cyc_q.delete();
        r0 = reads_seen; w0 = words_seen;
        push_bytes(8'h11, 8'h22, 8'h33, 8'h44, 4);
        for (int k = 0; k < 40 && words_seen < w0 + 1; k++) tick();
        repeat (4) tick();
        check("t1_word", 64'(last_word), 64'h44332211);
        check("t1_nbytes", 64'(last_nbytes), 64'd4);
        check("t1_reads", 64'(reads_seen - r0), 64'd4);
        check("t1_words", 64'(words_seen - w0), 64'd1);
        if (read_cyc_q.size() > 0 && rise_cyc_q.size() > 0)
            check("t1_latency", 64'(rise_cyc_q[0] - read_cyc_q[0]), 64'd6);
        else
            check("t1_latency_seen", 64'd0, 64'd1);

        // Two words with the sink stalled until both are packed.
        in_word_ready = 1'b0;
        r0 = reads_seen; w0 = words_seen;
        push_bytes(8'h01, 8'h02, 8'h03, 8'h04, 4);
        push_bytes(8'h05, 8'h06, 8'h07, 8'h08, 4);
        for (int k = 0; k < 40 && reads_seen < r0 + 8; k++) tick();
        repeat (6) tick();
        check("t2_stall_valid", {63'd0, out_word_valid}, 64'd1);
        check("t2_stall_data", 64'(out_word_data), 64'h04030201);
        check("t2_stall_reads", 64'(reads_seen - r0), 64'd8);
        check("t2_stall_noread", {63'd0, out_fifo_read}, 64'd0);
        in_word_ready = 1'b1;
        for (int k = 0; k < 40 && words_seen < w0 + 2; k++) tick();
        repeat (3) tick();
        check("t2_words", 64'(words_seen - w0), 64'd2);
        check("t2_last", 64'(last_word), 64'h08070605);

        // Partial-word flush, then a normal word.
        r0 = reads_seen; w0 = words_seen; f0 = flush_seen;
        push_bytes(8'hAA, 8'hBB, 8'h00, 8'h00, 2);
        for (int k = 0; k < 20 && reads_seen < r0 + 2; k++) tick();
        repeat (3) tick();
        in_flush = 1'b1; tick(); in_flush = 1'b0;
        for (int k = 0; k < 20 && (flush_seen < f0 + 1 || words_seen < w0 + 1); k++) tick();
        repeat (5) tick();
        check("t3_word", 64'(last_word), 64'h0000BBAA);
        check("t3_nbytes", 64'(last_nbytes), 64'd2);
        check("t3_one_pulse", 64'(flush_seen - f0), 64'd1);
        if (rise_cyc_q.size() > 0)
            check("t3_done_timing", {63'd0, (flush_cyc - rise_cyc_q[rise_cyc_q.size()-1]) inside {0, 1}}, 64'd1);
        w0 = words_seen;
        push_bytes(8'h66, 8'h77, 8'h88, 8'h99, 4);
        for (int k = 0; k < 40 && words_seen < w0 + 1; k++) tick();
        repeat (3) tick();
        check("t3_full_word", 64'(last_word), 64'h99887766);
        check("t3_full_nbytes", 64'(last_nbytes), 64'd4);

        // Flush with nothing assembled.
        repeat (5) tick();
        w0 = words_seen; f0 = flush_seen;
        in_flush = 1'b1; tick(); in_flush = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (out_flush_done) seen = 1'b1;
            if (k == 0) tick();
        end
        check("t4_done_within_2", {63'd0, seen}, 64'd1);
        repeat (5) tick();
        check("t4_no_word", 64'(words_seen - w0), 64'd0);
        check("t4_one_pulse", 64'(flush_seen - f0), 64'd1);

        // Reset with three bytes assembled and one read pending.
        r0 = reads_seen;
        push_bytes(8'hE1, 8'hE2, 8'hE3, 8'hE4, 4);
        for (int k = 0; k < 20 && reads_seen < r0 + 4; k++) tick();
        check("t5_reads_before_rst", 64'(reads_seen - r0), 64'd4);
        rst = 1'b1;
        tick();
        check("t5_rst_valid", {63'd0, out_word_valid}, 64'd0);
        check("t5_rst_data", 64'(out_word_data), 64'd0);
        check("t5_rst_nbytes", 64'(out_word_nbytes), 64'd0);
        check("t5_rst_flush_done", {63'd0, out_flush_done}, 64'd0);
        check("t5_rst_read", {63'd0, out_fifo_read}, 64'd0);
        rst = 1'b0;
        tick();
        w0 = words_seen;
        push_bytes(8'h55, 8'h56, 8'h57, 8'h58, 4);
        for (int k = 0; k < 40 && words_seen < w0 + 1; k++) tick();
        repeat (3) tick();
        check("t5_word", 64'(last_word), 64'h58575655);
        check("t5_words", 64'(words_seen - w0), 64'd1);

        // Random empty/ready toggling with occasional flushes, scoreboarded by the model.
        b0 = bytes_out;
        for (int i = 0; i < 1000; i++) src_q.push_back(8'($urandom));
        for (int c = 0; c < 30000 && (src_q.size() > 0 || !in_fifo_empty); c++) begin
            src_en        = ($urandom_range(0, 9) < 6);
            in_word_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 149) == 0) begin
                f0 = flush_seen;
                in_flush = 1'b1; tick(); in_flush = 1'b0;
                for (int k = 0; k < 200 && flush_seen < f0 + 1; k++) begin
                    in_word_ready = ($urandom_range(0, 9) < 6);
                    tick();
                end
                check("t6_flush_done", {63'd0, (flush_seen > f0)}, 64'd1);
            end else begin
                tick();
            end
        end
        src_en = 1'b1;
        repeat (4) tick();
        f0 = flush_seen;
        in_flush = 1'b1; tick(); in_flush = 1'b0;
        in_word_ready = 1'b1;
        for (int k = 0; k < 100 && (flush_seen < f0 + 1 || exp_q.size() > 0 || out_word_valid); k++) tick();
        repeat (3) tick();
        check("t6_drained", 64'(exp_q.size()), 64'd0);
        check("t6_bytes_out", 64'(bytes_out - b0), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
